// File: rtl/pixel_field_unpacker.sv
// rtl/pixel_field_unpacker.sv - unpacks packed pixel words into 1/2/4/8 bpp fields, LSB field first
module pixel_field_unpacker #(
    parameter int WORD_W = 32,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        bpp_mode,
    input  logic              flush,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_pixel,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] held_word;
    logic [1:0]        held_mode;
    logic [IDX_W-1:0]  idx;
    logic              full;

    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  shamt;
    logic [WORD_W-1:0] shifted;
    logic [7:0]        field;
    logic              idx_is_last;
    logic              pop;
    logic              load;

    assign last_idx    = IDX_W'((WORD_W >> held_mode) - 1);
    assign idx_is_last = (idx == last_idx);

    // idx * field_size never reaches WORD_W, so the bit offset fits in IDX_W bits
    assign shamt   = idx << held_mode;
    assign shifted = held_word >> shamt;

    always_comb begin
        field = '0;
        case (held_mode)
            2'd0:    field = {7'd0, shifted[0]};
            2'd1:    field = {6'd0, shifted[1:0]};
            2'd2:    field = {4'd0, shifted[3:0]};
            default: field = shifted[7:0];
        endcase
    end

    assign out_valid = full;
    assign out_pixel = full ? OUT_W'(field) : '0;
    assign pop       = out_valid && out_ready;
    assign in_ready  = !reset && !flush && (!full || (pop && idx_is_last));
    assign load      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            held_word <= '0;
            held_mode <= '0;
            idx       <= '0;
            full      <= 1'b0;
        end else if (flush) begin
            idx  <= '0;
            full <= 1'b0;
        end else if (load) begin
            // a load in the same cycle as the last pop keeps the buffer full
            held_word <= in_word;
            held_mode <= bpp_mode;
            idx       <= '0;
            full      <= 1'b1;
        end else if (pop) begin
            if (idx_is_last) begin
                full <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pixel_field_unpacker.sv
// tb/tb_pixel_field_unpacker.sv - directed scoreboard bench for pixel_field_unpacker
module tb_pixel_field_unpacker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  bpp_mode = 2'd0;
    logic        flush = 1'b0;
    logic [31:0] in_word = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_pixel;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int passed = 0;
    int pops = 0;
    int pops0 = 0;
    logic [7:0] q[$];

    pixel_field_unpacker #(.WORD_W(32), .OUT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .bpp_mode(bpp_mode),
        .flush(flush),
        .in_word(in_word),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_pixel(out_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [31:0] w, input logic [1:0] mode);
        int fs;
        logic [31:0] mask;
        fs   = 1 << mode;
        mask = (32'd1 << fs) - 32'd1;
        for (int i = 0; i < (32 >> mode); i++)
            q.push_back(8'((w >> (i * fs)) & mask));
    endtask

    // sample settled outputs mid-cycle and run the scoreboard
    task automatic settle();
        logic [7:0] e;
        #1;
        if (reset) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                check("pending_pixel", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("pixel", 32'(out_pixel), 32'(e));
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) push_word(in_word, bpp_mode);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        // reset state
        advance();
        advance();
        settle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pixel", 32'(out_pixel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        advance();
        reset = 1'b0;
        settle();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        advance();

        // 8 bpp back-to-back
        bpp_mode = 2'd3; in_word = 32'h44332211; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c >= 1) in_word = 32'h88776655;
            if (c == 8) in_valid = 1'b0;
            settle();
            if (c < 8) check("b2b_in_ready", 32'(in_ready), 32'((c == 0) || (c == 4)));
            if (c >= 1) check("b2b_out_valid", 32'(out_valid), 32'd1);
            advance();
        end
        settle();
        check("b2b_drained", 32'(out_valid), 32'd0);
        advance();

        // 2 bpp
        bpp_mode = 2'd1; in_word = 32'hE4E4E4E4; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            settle();
            check("2bpp_pixel", 32'(out_pixel), 32'((c - 1) % 4));
            check("2bpp_in_ready", 32'(in_ready), 32'(c == 16));
            advance();
        end

        // 1 bpp with stall
        bpp_mode = 2'd0; in_word = 32'h00000005; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        pops0 = pops;
        cyc();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("stall_pixel", 32'(out_pixel), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            advance();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 31; c++) cyc();
        check("1bpp_pops", 32'(pops - pops0), 32'd32);
        settle();
        check("1bpp_done", 32'(out_valid), 32'd0);
        advance();

        // bpp_mode change mid-word
        bpp_mode = 2'd2; in_word = 32'hA5A5A5A5; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        bpp_mode = 2'd3;
        for (int c = 0; c < 6; c++) cyc();
        check("nibble_count", 32'(q.size()), 32'd0);
        settle();
        check("mode_word_done", 32'(out_valid), 32'd0);
        advance();
        in_word = 32'h12345678; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        settle();
        check("byte0", 32'(out_pixel), 32'h78);
        advance();
        for (int c = 0; c < 3; c++) cyc();
        check("byte_count", 32'(q.size()), 32'd0);

        // flush
        bpp_mode = 2'd3; in_word = 32'hDDCCBBAA; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        flush = 1'b1; in_valid = 1'b1; in_word = 32'h55667788;
        settle();
        check("flush_in_ready", 32'(in_ready), 32'd0);
        advance();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        check("post_flush_valid", 32'(out_valid), 32'd0);
        check("post_flush_pixel", 32'(out_pixel), 32'd0);
        advance();
        in_word = 32'h04030201; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        settle();
        check("after_flush_field0", 32'(out_pixel), 32'h01);
        advance();
        for (int c = 0; c < 3; c++) cyc();

        // reset mid-word at field 2 of a 4 bpp word
        bpp_mode = 2'd2; in_word = 32'h87654321; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        out_ready = 1'b0;
        settle();
        check("pre_reset_field2", 32'(out_pixel), 32'd3);
        advance();
        reset = 1'b1;
        settle();
        check("reset_in_ready", 32'(in_ready), 32'd0);
        advance();
        settle();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_pixel", 32'(out_pixel), 32'd0);
        check("reset_in_ready2", 32'(in_ready), 32'd0);
        advance();
        reset = 1'b0; out_ready = 1'b1;
        settle();
        check("release_in_ready", 32'(in_ready), 32'd1);
        advance();

        check("drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
